led_status_ctrl: RTL and testbench
==================================

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of independent LED channels (1..32).
REQ-002 SHALL have parameter PRESCALE, default 50000: clk50m cycles per tick, giving 1 kHz at 50 MHz; value >= 2.
REQ-003 SHALL have parameter BLINK_TICKS, default 250: ticks per blink half-period; value >= 1.
REQ-004 SHALL have parameter STRETCH_TICKS, default 100: pulse-stretch length in ticks; value >= 1.
REQ-005 SHALL have parameters HB_PERIOD, default 1000, and HB_ON, default 100: heartbeat period and on-time in ticks; HB_ON < HB_PERIOD.
REQ-006 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts every led output.
REQ-007 SHALL have port clk50m, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port reset_rtl_0, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port status_in, input, NUM_LEDS bits: per-channel status, asynchronous to clk50m (e.g. init_calib_complete, GPIO).
REQ-010 SHALL have port mode, input, 2*NUM_LEDS bits: channel i mode is mode[2i+1:2i]; synchronous to clk50m.
REQ-011 SHALL have port led, output, NUM_LEDS bits: registered LED drive.

Function
REQ-012 SHALL pass each status_in bit through a 2-flop synchroniser followed by a third flop for edge detection; all three reset to 0.
REQ-013 SHALL run one shared prescaler counting 0..PRESCALE-1; a one-cycle tick is asserted when count = PRESCALE-1, and the count wraps to 0 on that cycle.
REQ-014 SHALL hold one shared blink counter 0..BLINK_TICKS-1 that advances on tick; blink_phase toggles on every wrap. Reset: counter 0, blink_phase 0.
REQ-015 SHALL hold one shared heartbeat counter 0..HB_PERIOD-1 that advances on tick and wraps; hb_on = (count < HB_ON).
REQ-016 SHALL hold one stretch counter per channel, running in every mode:
- rising edge of the synchronised input (sync2=1, sync3=0): load STRETCH_TICKS;
- else on tick with counter nonzero: decrement;
- load takes priority over a simultaneous tick;
- retrigger while counting reloads the full length;
- saturates at 0.
REQ-017 SHALL compute channel "on" from mode:
- 00 static: on = sync2;
- 01 blink: on = sync2 AND blink_phase;
- 10 stretch: on = (stretch counter != 0);
- 11 heartbeat: on = hb_on, status ignored.
REQ-018 SHALL register led[i] = on XOR ACTIVE_LOW every cycle; a mode change takes effect at the next rising edge.
REQ-019 SHALL in static mode make a status_in level captured at edge N appear on led at edge N+2, giving 3-edge worst-case latency from an asynchronous change.
REQ-020 SHALL size every counter with $clog2 of its range, and SHALL have no wrap-around beyond the stated ranges.

Reset
REQ-021 SHALL on reset_rtl_0 asserted immediately clear the synchronisers, the prescaler, the blink, heartbeat and stretch counters, and blink_phase, and drive led to all-off (all 0, or all 1 if ACTIVE_LOW), independent of the clock.
REQ-022 SHALL on reset deassertion resume from the cleared state; the first tick occurs PRESCALE cycles after the first post-reset edge.
REQ-023 SHALL when reset is asserted mid-stretch or mid-blink abort the activity with no residual on-time after release.

Verification (PRESCALE=4, BLINK_TICKS=2, STRETCH_TICKS=3, HB_PERIOD=8, HB_ON=2, NUM_LEDS=4)
REQ-024 SHALL verify static mode: mode=00, status_in[0] 0->1 sampled at edge N -> led[0]=1 at edge N+2; return to 0 -> led[0]=0 after the same latency.
REQ-025 SHALL verify blink mode: mode=01, status_in[1] held 1 -> led[1] toggles every 8 cycles (2 ticks x 4); status_in low -> led[1] stays 0.
REQ-026 SHALL verify stretch mode:
- a 1-cycle status_in[2] pulse -> led[2] high for 3 ticks (9-12 cycles depending on prescaler phase);
- a second pulse mid-stretch -> reloads to 3 ticks;
- an edge coincident with a tick -> load wins.
REQ-027 SHALL verify heartbeat mode: mode=11, status_in arbitrary -> led[3] high 2 ticks (8 cycles) of every 8 ticks (32 cycles).
REQ-028 SHALL verify reset: reset_rtl_0 pulsed mid-stretch with no clock edge -> led=0000 immediately; after release no residual stretch; ACTIVE_LOW=1 build -> led=1111 in reset.

Source files
------------

// File: rtl/led_status_ctrl.sv
// -----------------------------------------------------------------------------
// led_status_ctrl
//
// Purpose
//   Drives NUM_LEDS status LEDs from asynchronous status inputs. Each channel
//   synchronises its input, then lights its LED in one of four modes: static,
//   blink, pulse-stretch or heartbeat. One prescaler, one blink counter and one
//   heartbeat counter are shared by all channels. Each channel has its own
//   stretch counter.
//
// Ports
//   clk50m       in   1         single clock, rising edge
//   reset_rtl_0  in   1         asynchronous, active-high reset
//   status_in    in   NUM_LEDS  per-channel status, asynchronous to clk50m
//   mode         in   2*NUM_LEDS channel i mode = mode[2i+1:2i], synchronous
//                               00 static, 01 blink, 10 stretch, 11 heartbeat
//   led          out  NUM_LEDS  registered LED drive (inverted if ACTIVE_LOW)
// -----------------------------------------------------------------------------
module led_status_ctrl #(
    parameter int NUM_LEDS      = 8,
    parameter int PRESCALE      = 50000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 100,
    parameter int HB_PERIOD     = 1000,
    parameter int HB_ON         = 100,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                  clk50m,
    input  logic                  reset_rtl_0,
    input  logic [NUM_LEDS-1:0]   status_in,
    input  logic [2*NUM_LEDS-1:0] mode,
    output logic [NUM_LEDS-1:0]   led
);

    // Counter widths. Ranges of a single value still get one bit so that no
    // zero-width vector is ever declared.
    localparam int PRE_W = (PRESCALE > 1)    ? $clog2(PRESCALE)    : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int HB_W  = (HB_PERIOD > 1)   ? $clog2(HB_PERIOD)   : 1;
    // The stretch counter holds 0..STRETCH_TICKS inclusive.
    localparam int STR_W = $clog2(STRETCH_TICKS + 1);

    localparam logic [PRE_W-1:0]    PRE_MAX     = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_MAX     = BLK_W'(BLINK_TICKS - 1);
    localparam logic [HB_W-1:0]     HB_MAX      = HB_W'(HB_PERIOD - 1);
    localparam logic [HB_W-1:0]     HB_ON_V     = HB_W'(HB_ON);
    localparam logic [STR_W-1:0]    STR_LOAD    = STR_W'(STRETCH_TICKS);
    localparam logic [NUM_LEDS-1:0] OFF_PATTERN = {NUM_LEDS{ACTIVE_LOW != 0}};

    // Synchroniser chain: r_sync1/r_sync2 are the 2-flop synchroniser,
    // r_sync3 is the delayed copy used for rising-edge detection.
    logic [NUM_LEDS-1:0] r_sync1;
    logic [NUM_LEDS-1:0] r_sync2;
    logic [NUM_LEDS-1:0] r_sync3;
    logic [NUM_LEDS-1:0] w_rise;

    logic [PRE_W-1:0]    r_pre;
    logic                w_tick;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic                r_blink_phase;
    logic [HB_W-1:0]     r_hb_cnt;
    logic                w_hb_on;
    logic [STR_W-1:0]    r_stretch [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_on;
    logic [NUM_LEDS-1:0] r_led;

    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= status_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    // Shared prescaler: tick is high for the single cycle at the top count.
    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            r_pre <= '0;
        end else if (r_pre == PRE_MAX) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = (r_pre == PRE_MAX);

    // Shared blink counter: the phase flips every BLINK_TICKS ticks.
    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_blk_cnt == BLK_MAX) begin
                r_blk_cnt     <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    // Shared heartbeat counter.
    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            r_hb_cnt <= '0;
        end else if (w_tick) begin
            if (r_hb_cnt == HB_MAX) begin
                r_hb_cnt <= '0;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign w_hb_on = (r_hb_cnt < HB_ON_V);

    // Per-channel stretch counters run in every mode so that switching into
    // stretch mode shows any pulse already in flight. A rising edge reloads
    // the full length and wins over a decrement on the same cycle.
    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_rise[i]) begin
                    r_stretch[i] <= STR_LOAD;
                end else if (w_tick && (r_stretch[i] != '0)) begin
                    r_stretch[i] <= r_stretch[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode[2*i +: 2])
                2'b00:   w_on[i] = r_sync2[i];
                2'b01:   w_on[i] = r_sync2[i] & r_blink_phase;
                2'b10:   w_on[i] = (r_stretch[i] != '0);
                default: w_on[i] = w_hb_on;
            endcase
        end
    end

    always_ff @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            r_led <= OFF_PATTERN;
        end else begin
            r_led <= w_on ^ OFF_PATTERN;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_led_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_status_ctrl
//
// Small build: PRESCALE=4, BLINK_TICKS=2, STRETCH_TICKS=3, HB_PERIOD=8,
// HB_ON=2, NUM_LEDS=4. Channel modes: ch0 static, ch1 blink, ch2 stretch,
// ch3 heartbeat. A second instance is built with ACTIVE_LOW=1 and checked
// against the inverted expectation.
//
// cyc counts rising edges since the last reset release (edge 1 = first edge
// after release). Ticks take effect on edges that are multiples of 4.
// Inputs are driven 1 ns after a falling edge at cyc = n, so they are sampled
// at edge n+1; a static level therefore shows on led at cyc n+3.
// -----------------------------------------------------------------------------
module tb_led_status_ctrl;

    localparam int N = 4;

    logic           clk50m = 1'b0;
    logic           reset_rtl_0 = 1'b0;
    logic [N-1:0]   status_in = '0;
    logic [2*N-1:0] mode = 8'b11_10_01_00;
    logic [N-1:0]   led;
    logic [N-1:0]   led_n;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    // Scoreboard: expected led value, bit mask and check cycle per entry.
    logic [N-1:0] exp_q[$];
    logic [N-1:0] mask_q[$];
    int           cyc_q[$];
    string        name_q[$];

    led_status_ctrl #(
        .NUM_LEDS(N), .PRESCALE(4), .BLINK_TICKS(2), .STRETCH_TICKS(3),
        .HB_PERIOD(8), .HB_ON(2), .ACTIVE_LOW(0)
    ) dut (
        .clk50m(clk50m), .reset_rtl_0(reset_rtl_0), .status_in(status_in),
        .mode(mode), .led(led)
    );

    led_status_ctrl #(
        .NUM_LEDS(N), .PRESCALE(4), .BLINK_TICKS(2), .STRETCH_TICKS(3),
        .HB_PERIOD(8), .HB_ON(2), .ACTIVE_LOW(1)
    ) dut_n (
        .clk50m(clk50m), .reset_rtl_0(reset_rtl_0), .status_in(status_in),
        .mode(mode), .led(led_n)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    always #5 clk50m = ~clk50m;

    always @(posedge clk50m or posedge reset_rtl_0) begin
        if (reset_rtl_0) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push_exp(input int c, input logic [N-1:0] m, input logic [N-1:0] v, input string nm);
        cyc_q.push_back(c);
        mask_q.push_back(m);
        exp_q.push_back(v);
        name_q.push_back($sformatf("%s_c%0d", nm, c));
    endtask

    // Wait for the falling edge at cyc == n, then step 1 ns off the edge.
    task automatic at_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge clk50m);
            guard++;
        end while (cyc != n && guard < 3000);
        if (cyc != n) begin
            n_total++;
            $display("FAIL at_cyc_%0d: got cyc %0d expected %0d", n, cyc, n);
        end
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk50m) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (cyc_q[i] == cyc) begin
                check(name_q[i], led & mask_q[i], exp_q[i] & mask_q[i]);
                check({name_q[i], "_al"}, led_n & mask_q[i], ~exp_q[i] & mask_q[i]);
            end else if (cyc_q[i] < cyc) begin
                n_total++;
                $display("FAIL %s: got no check at cyc %0d expected one", name_q[i], cyc_q[i]);
            end
            if (cyc_q[i] <= cyc) begin
                exp_q.delete(i);
                mask_q.delete(i);
                cyc_q.delete(i);
                name_q.delete(i);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #2 reset_rtl_0 = 1'b1;
        #1;
        check("reset_init_led", led, 4'b0000);
        check("reset_init_led_al", led_n, 4'b1111);

        // heartbeat ch3: on for cyc in [1,9) mod 32
        push_exp(1,  4'b1000, 4'b1000, "hb_on");
        push_exp(8,  4'b1000, 4'b1000, "hb_on_end");
        push_exp(9,  4'b1000, 4'b0000, "hb_off");
        push_exp(32, 4'b1000, 4'b0000, "hb_off_end");
        push_exp(33, 4'b1000, 4'b1000, "hb_on2");
        push_exp(40, 4'b1000, 4'b1000, "hb_on2_end");
        push_exp(41, 4'b1000, 4'b0000, "hb_off2");
        // blink ch1 with status low: phase is 1 here but led stays off
        push_exp(10, 4'b0010, 4'b0000, "blink_low");
        #19 reset_rtl_0 = 1'b0;

        at_cyc(5);
        status_in[3] = 1'b1;  // heartbeat ignores status

        // static ch0
        at_cyc(10);
        push_exp(12, 4'b0001, 4'b0000, "static_rise_pre");
        push_exp(13, 4'b0001, 4'b0001, "static_rise");
        status_in[0] = 1'b1;
        at_cyc(20);
        push_exp(22, 4'b0001, 4'b0001, "static_fall_pre");
        push_exp(23, 4'b0001, 4'b0000, "static_fall");
        status_in[0] = 1'b0;

        // blink ch1: sync2 high from edge 32, phase high on cyc 41..48, 57..64
        at_cyc(30);
        push_exp(40, 4'b0010, 4'b0000, "blink_off");
        push_exp(41, 4'b0010, 4'b0010, "blink_on");
        push_exp(48, 4'b0010, 4'b0010, "blink_on_end");
        push_exp(49, 4'b0010, 4'b0000, "blink_off2");
        push_exp(56, 4'b0010, 4'b0000, "blink_off2_end");
        push_exp(57, 4'b0010, 4'b0010, "blink_on2");
        status_in[1] = 1'b1;

        // stretch ch2, single pulse: load at edge 63, zero at edge 72
        at_cyc(60);
        push_exp(63, 4'b0100, 4'b0000, "stretch_pre");
        push_exp(64, 4'b0100, 4'b0100, "stretch_on");
        push_exp(72, 4'b0100, 4'b0100, "stretch_last");
        push_exp(73, 4'b0100, 4'b0000, "stretch_off");
        status_in[2] = 1'b1;
        at_cyc(61);
        status_in[2] = 1'b0;

        // retrigger: loads at 83 and 89, zero at edge 100
        at_cyc(80);
        push_exp(92, 4'b0100, 4'b0100, "retrig_mid");
        push_exp(100, 4'b0100, 4'b0100, "retrig_last");
        push_exp(101, 4'b0100, 4'b0000, "retrig_off");
        status_in[2] = 1'b1;
        at_cyc(81);
        status_in[2] = 1'b0;
        at_cyc(86);
        status_in[2] = 1'b1;
        at_cyc(87);
        status_in[2] = 1'b0;

        // reload coincident with tick at edge 120: load wins, zero at edge 132
        at_cyc(110);
        push_exp(121, 4'b0100, 4'b0100, "coinc_on");
        push_exp(128, 4'b0100, 4'b0100, "coinc_mid");
        push_exp(132, 4'b0100, 4'b0100, "coinc_last");
        push_exp(133, 4'b0100, 4'b0000, "coinc_off");
        status_in[2] = 1'b1;
        at_cyc(111);
        status_in[2] = 1'b0;
        at_cyc(117);
        status_in[2] = 1'b1;
        at_cyc(118);
        status_in[2] = 1'b0;

        // set up for reset: ch0 static on, ch2 mid-stretch (load at 143)
        at_cyc(135);
        push_exp(146, 4'b1111, 4'b0101, "pre_reset");
        status_in[0] = 1'b1;
        at_cyc(140);
        status_in[2] = 1'b1;
        at_cyc(141);
        status_in[2] = 1'b0;

        // async reset between edges
        at_cyc(146);
        reset_rtl_0 = 1'b1;
        #1;
        check("reset_async_led", led, 4'b0000);
        check("reset_async_led_al", led_n, 4'b1111);

        // after release: ch0 re-synchronises, no residual stretch, blink and
        // heartbeat restart from zero
        push_exp(1,  4'b1111, 4'b1000, "post_rst");
        push_exp(2,  4'b1111, 4'b1000, "post_rst");
        push_exp(3,  4'b1111, 4'b1001, "post_rst");
        push_exp(8,  4'b1111, 4'b1001, "post_rst");
        push_exp(9,  4'b1111, 4'b0011, "post_rst");
        push_exp(12, 4'b1111, 4'b0011, "mode_chg_pre");
        push_exp(13, 4'b1111, 4'b1011, "mode_chg");

        repeat (3) @(negedge clk50m);
        check("reset_held_led", led, 4'b0000);
        check("reset_held_led_al", led_n, 4'b1111);
        #2 reset_rtl_0 = 1'b0;

        // ch3 heartbeat -> static; status_in[3] is high
        at_cyc(12);
        mode[7:6] = 2'b00;

        at_cyc(16);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending checks expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
